lfsr_rng_ctrl: RTL
==================

LFSR_RNG_CTRL -- requirements
Module: lfsr_rng_ctrl

Interface
REQ-001 Parameter RESET_SEED, default 5'b00001: LFSR state loaded at reset; nonzero.
REQ-002 clk  input  1  rising-edge clock; the block SHALL use this single clock.
REQ-003 rst_n  input  1  reset; the block SHALL treat it as asynchronous and active-low.
REQ-004 seed_load_i  input  1  seed load strobe.
REQ-005 seed_i  input  5  seed value.
REQ-006 req_valid_i  input  1  step request valid.
REQ-007 req_count_i  input  5  number of LFSR steps for the request, 0..31.
REQ-008 req_ready_o  output  1  request accepted when high with req_valid_i.
REQ-009 rsp_valid_o  output  1  result valid.
REQ-010 rsp_data_o  output  5  LFSR state after the requested steps.
REQ-011 rsp_ready_i  input  1  consumer accepts result.
REQ-012 busy_o  output  1  high in RUN or HOLD.
REQ-013 seed_err_o  output  1  one-cycle pulse on zero-seed substitution.

Function
REQ-014 LFSR step SHALL be: s0<=s4, s1<=s0, s2<=s1^s4, s3<=s2, s4<=s3 (internal XOR, period 31).
REQ-015 FSM SHALL have states IDLE, RUN and HOLD.
REQ-016 IDLE: req_ready_o=1. Handshake req_valid_i&req_ready_o SHALL latch req_count_i into a 5-bit down-counter; next state RUN if count>0, else HOLD.
REQ-017 RUN: the LFSR SHALL advance exactly one step per cycle and the counter SHALL decrement; on the cycle where counter==1, next state HOLD.
REQ-018 Latency: for count K>=1, rsp_valid_o SHALL rise K+1 cycles after the acceptance edge; for K=0, 1 cycle after.
REQ-019 HOLD: rsp_valid_o=1 and rsp_data_o=LFSR state, both stable until rsp_ready_i; on handshake next state IDLE; the LFSR SHALL NOT advance in HOLD.
REQ-020 rsp_data_o SHALL be driven with the LFSR state in all states; it is qualified only by rsp_valid_o.
REQ-021 seed_load_i SHALL be honoured only in IDLE; it is ignored in RUN and HOLD with no error.
REQ-022 seed_i==0 with an honoured load SHALL load 5'b00001 and pulse seed_err_o for one cycle.
REQ-023 Simultaneous seed load and request in IDLE: the seed SHALL be loaded at the same edge and stepping SHALL start from the new seed.
REQ-024 The LFSR SHALL never hold all-zeros; a detected zero state (fault) SHALL be forced to 5'b00001 on the next edge.
REQ-025 The counter SHALL never wrap; count 31 yields exactly 31 steps.
REQ-026 req_ready_o SHALL be 0 in RUN and HOLD; back-to-back requests need at least one IDLE cycle.

Reset
REQ-027 On rst_n low, asynchronously: state=IDLE, LFSR=RESET_SEED, counter=0, rsp_valid_o=0, busy_o=0, seed_err_o=0, req_ready_o=1 (after release), rsp_data_o=RESET_SEED.
REQ-028 Reset mid-RUN or mid-HOLD SHALL abort the request with no response.

Structure
REQ-029 A shared package SHALL hold the FSM state enum (IDLE/RUN/HOLD), LFSR width constant 5 and the zero-seed substitute constant 5'b00001.
REQ-030 The LFSR register and next-state logic SHALL be one sub-module, lfsr5_core (ports: clk, rst_n, load, load_val, step, state); the FSM and counter SHALL live in lfsr_rng_ctrl.

Verification
REQ-031 Reset, then request K=1 with rsp_ready_i=1 -> rsp_valid_o two cycles after acceptance, rsp_data_o=5'b00010.
REQ-032 Request K=31 from RESET_SEED -> rsp_data_o=5'b00001 (full period); K=0 -> rsp_data_o unchanged, one cycle latency.
REQ-033 seed_load_i=1 with seed_i=0 in IDLE -> state 5'b00001, seed_err_o high exactly one cycle.
REQ-034 Hold rsp_ready_i=0 for 10 cycles in HOLD -> rsp_valid_o and rsp_data_o stable, LFSR not advancing, req_ready_o=0.
REQ-035 seed_load_i during RUN -> ignored, result equals the no-load result; simultaneous load+request in IDLE -> steps start from the new seed.
REQ-036 Assert rst_n low mid-RUN (K=20, after 5 steps) -> outputs at reset values immediately, no rsp_valid_o after release.

Source files
------------

// File: rtl/lfsr_rng_ctrl_pkg.sv
// Shared types and constants for the LFSR random-number controller.
// Holds the FSM state encoding, LFSR width, zero-seed substitute and step function.
package lfsr_rng_ctrl_pkg;

  localparam int unsigned LfsrWidth = 5;

  localparam logic [LfsrWidth-1:0] SeedSubst = 5'b00001;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StHold
  } state_e;

  // Internal-XOR Galois step with taps giving a maximal period of 31.
  function automatic logic [LfsrWidth-1:0] lfsr_next(input logic [LfsrWidth-1:0] s);
    lfsr_next = {s[3], s[2], s[1] ^ s[4], s[0], s[4]};
  endfunction

endpackage

// File: rtl/lfsr5_core.sv
// 5-bit LFSR register with load, single-step advance and all-zero recovery.
// Load has priority over stepping; a zero state is forced back to the substitute seed.
module lfsr5_core
  import lfsr_rng_ctrl_pkg::*;
#(
  parameter logic [LfsrWidth-1:0] RESET_SEED = 5'b00001
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic [LfsrWidth-1:0] load_val,
  input  logic                 step,
  output logic [LfsrWidth-1:0] state
);

  logic [LfsrWidth-1:0] state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = (load_val == '0) ? SeedSubst : load_val;
    end else if (state_q == '0) begin
      // Lock-up state is unreachable in normal operation; recover from upsets.
      state_d = SeedSubst;
    end else if (step) begin
      state_d = lfsr_next(state_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RESET_SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/lfsr_rng_ctrl.sv
// Request/response controller that advances a 5-bit LFSR a requested number of steps.
// The result is held with rsp_valid_o until the consumer accepts it.
module lfsr_rng_ctrl
  import lfsr_rng_ctrl_pkg::*;
#(
  parameter logic [LfsrWidth-1:0] RESET_SEED = 5'b00001
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 seed_load_i,
  input  logic [LfsrWidth-1:0] seed_i,
  input  logic                 req_valid_i,
  input  logic [LfsrWidth-1:0] req_count_i,
  output logic                 req_ready_o,
  output logic                 rsp_valid_o,
  output logic [LfsrWidth-1:0] rsp_data_o,
  input  logic                 rsp_ready_i,
  output logic                 busy_o,
  output logic                 seed_err_o
);

  state_e               state_q, state_d;
  logic [LfsrWidth-1:0] cnt_q, cnt_d;
  logic                 seed_err_q, seed_err_d;
  logic                 seed_zero;
  logic                 lfsr_load;
  logic                 lfsr_step;
  logic [LfsrWidth-1:0] lfsr_load_val;
  logic [LfsrWidth-1:0] lfsr_state;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    seed_err_d    = 1'b0;
    lfsr_load     = 1'b0;
    lfsr_step     = 1'b0;
    req_ready_o   = 1'b0;
    rsp_valid_o   = 1'b0;
    busy_o        = 1'b0;
    seed_zero     = (seed_i == '0);
    lfsr_load_val = seed_zero ? SeedSubst : seed_i;

    unique case (state_q)
      StIdle: begin
        req_ready_o = 1'b1;
        // A load coinciding with a request lands on the same edge, so RUN steps the new seed.
        if (seed_load_i) begin
          lfsr_load  = 1'b1;
          seed_err_d = seed_zero;
        end
        if (req_valid_i) begin
          cnt_d   = req_count_i;
          state_d = (req_count_i != '0) ? StRun : StHold;
        end
      end
      StRun: begin
        busy_o    = 1'b1;
        lfsr_step = 1'b1;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 5'd1;
        end
        if (cnt_q <= 5'd1) begin
          state_d = StHold;
        end
      end
      StHold: begin
        busy_o      = 1'b1;
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      seed_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      seed_err_q <= seed_err_d;
    end
  end

  lfsr5_core #(
    .RESET_SEED (RESET_SEED)
  ) u_lfsr5_core (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (lfsr_load),
    .load_val (lfsr_load_val),
    .step     (lfsr_step),
    .state    (lfsr_state)
  );

  assign rsp_data_o = lfsr_state;
  assign seed_err_o = seed_err_q;

endmodule
